fp_div_seq: RTL
===============

FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL take no parameters; DATA_WIDTH comes from pkg_opengpu and is 32 (IEEE 754 single).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operands presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port operand_a  input  DATA_WIDTH  dividend.
REQ-007 SHALL have port operand_b  input  DATA_WIDTH  divisor.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  DATA_WIDTH  quotient a/b.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, ROUND, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; accept = in_valid && in_ready; operands captured into internal registers on accept.
REQ-014 SHALL, on accept of a special-case pair, compute the result immediately and go IDLE->DONE (out_valid high the next cycle).
REQ-015 SHALL apply special cases in priority order: either NaN -> 7FC00000; inf/inf or 0/0 -> 7FC00000; inf/finite -> signed inf; finite/0 -> signed inf; 0/finite or finite/inf -> signed zero; sign = sign_a ^ sign_b.
REQ-016 SHALL treat denormal inputs as zero of the same sign (DAZ) and flush underflowing results to signed zero (FTZ).
REQ-017 SHALL, for normal/normal, form 24-bit mantissas with implicit 1; if mant_a < mant_b, shift mant_a left 1 and subtract 1 from exponent so quotient lies in [1,2).
REQ-018 SHALL keep the exponent as a 10-bit signed value: exp = exp_a - exp_b + 127 (-1 if prescaled).
REQ-019 SHALL, in CALC, run radix-2 restoring division producing one quotient bit per cycle for exactly 26 cycles (24 mantissa + guard + round), counted by a 5-bit iteration counter.
REQ-020 SHALL set sticky = (final remainder != 0).
REQ-021 SHALL, in ROUND (1 cycle), round to nearest, ties to even using guard/round/sticky; a mantissa carry-out SHALL increment the exponent and zero the fraction.
REQ-022 SHALL, in ROUND, produce signed inf (exp field FF, fraction 0) when rounded exp >= 255 and signed zero when rounded exp <= 0.
REQ-023 SHALL give normal-path latency of 28 cycles: accept at edge N, out_valid high after edge N+28 (26 CALC + 1 ROUND + DONE entry).
REQ-024 SHALL hold out_valid and result stable in DONE until out_valid && out_ready; then go DONE->IDLE, in_ready high the following cycle.
REQ-025 SHALL ignore in_valid in every state except IDLE; operand changes after accept SHALL NOT affect the result.
REQ-026 SHALL keep result at its last value while in IDLE; out_valid=0 outside DONE.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, enter IDLE with out_valid=0, result=0, busy=0, counter=0, in_ready=1 the next cycle.
REQ-028 SHALL, on rst asserted mid-CALC/ROUND/DONE, abort the operation; no result is ever presented for it.
REQ-029 SHALL give rst priority over accept and over output handshake on the same edge.

Verification
REQ-030 SHALL check 40C00000 / 40000000 (6/2) -> result 40400000, out_valid exactly 28 cycles after accept.
REQ-031 SHALL check 3F800000 / 40400000 (1/3) -> 3EAAAAAB (RNE round-up via sticky).
REQ-032 SHALL check 3F800000 / 00000000 -> 7F800000 and 00000000 / 80000000 -> 7FC00000, each with out_valid 1 cycle after accept.
REQ-033 SHALL check 7F7FFFFF / 3F000000 -> 7F800000 and 00800000 / 4B000000 -> 00000000.
REQ-034 SHALL check backpressure: out_ready low 10 cycles in DONE -> result, out_valid stable, in_ready 0; in_valid pulses ignored.
REQ-035 SHALL check rst pulse at CALC cycle 12 -> IDLE, out_valid never asserted for that op; next 6/2 yields 40400000.

Source files
------------

// File: rtl/fp_div_seq.sv
// -----------------------------------------------------------------------------
// fp_div_seq -- sequential IEEE 754 single-precision divider (a / b).
//
// Operation
//   - Operands are accepted with a valid/ready handshake.
//   - Special operand pairs are resolved at accept time.
//   - A normal/normal quotient is produced by 26 cycles of radix-2 restoring
//     division, followed by one round-to-nearest-even cycle.
//   - Denormal inputs are treated as zero, and underflowing results are
//     flushed to zero.
//   - The result is held in DONE until the consumer takes it.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operands presented
//   in_ready   out  block can accept operands (IDLE only)
//   operand_a  in   dividend, DATA_WIDTH bits
//   operand_b  in   divisor, DATA_WIDTH bits
//   out_valid  out  result available (DONE only)
//   out_ready  in   consumer accepts result
//   result     out  quotient a/b, DATA_WIDTH bits
//   busy       out  high in any state other than IDLE
// -----------------------------------------------------------------------------
package pkg_opengpu;
    localparam int DATA_WIDTH = 32;
endpackage

module fp_div_seq
    import pkg_opengpu::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_result;
    logic [4:0]            r_count;
    logic                  r_sign;
    logic signed [9:0]     r_exp;
    logic [25:0]           r_rem;
    logic [23:0]           r_mant_b;
    // Only the last 25 quotient bits are kept. The integer bit is always 1
    // and is shifted out: [24:2] fraction, [1] guard, [0] round.
    logic [24:0]           r_quot;

    // Operand decode
    logic [7:0]  w_a_exp;
    logic [7:0]  w_b_exp;
    logic [22:0] w_a_frac;
    logic [22:0] w_b_frac;
    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_sign;
    logic        w_special;
    logic [31:0] w_special_res;
    logic [23:0] w_mant_a;
    logic [23:0] w_mant_b;
    logic        w_pre;
    logic [25:0] w_rem_init;
    logic [9:0]  w_exp_init;

    // Iteration datapath
    logic        w_ge;
    logic [24:0] w_rem_sub;
    logic [25:0] w_rem_next;

    // Rounding datapath
    logic        w_sticky;
    logic        w_round_up;
    logic [23:0] w_frac_sum;
    logic        w_carry;
    logic signed [9:0] w_exp_rnd;
    logic [22:0] w_frac_rnd;
    logic [31:0] w_round_res;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = r_busy;

    // Operand classification, special-case result and normal-path setup
    always_comb begin
        w_a_exp  = operand_a[30:23];
        w_b_exp  = operand_b[30:23];
        w_a_frac = operand_a[22:0];
        w_b_frac = operand_b[22:0];
        // A zero exponent field covers both true zero and denormals.
        w_a_zero = (w_a_exp == 8'h00);
        w_b_zero = (w_b_exp == 8'h00);
        w_a_inf  = (w_a_exp == 8'hFF) && (w_a_frac == 23'd0);
        w_b_inf  = (w_b_exp == 8'hFF) && (w_b_frac == 23'd0);
        w_a_nan  = (w_a_exp == 8'hFF) && (w_a_frac != 23'd0);
        w_b_nan  = (w_b_exp == 8'hFF) && (w_b_frac != 23'd0);
        w_sign   = operand_a[31] ^ operand_b[31];

        w_special     = 1'b1;
        w_special_res = 32'd0;
        if (w_a_nan || w_b_nan) begin
            w_special_res = QNAN;
        end else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
            w_special_res = QNAN;
        end else if (w_a_inf || w_b_zero) begin
            w_special_res = {w_sign, 8'hFF, 23'd0};
        end else if (w_a_zero || w_b_inf) begin
            w_special_res = {w_sign, 31'd0};
        end else begin
            w_special     = 1'b0;
            w_special_res = 32'd0;
        end

        w_mant_a = {1'b1, w_a_frac};
        w_mant_b = {1'b1, w_b_frac};
        // Prescale the dividend so that the quotient lies in [1,2).
        w_pre    = (w_mant_a < w_mant_b);
        if (w_pre) begin
            w_rem_init = {1'b0, w_mant_a, 1'b0};
        end else begin
            w_rem_init = {2'b00, w_mant_a};
        end
        w_exp_init = {2'b00, w_a_exp} - {2'b00, w_b_exp} + 10'd127 - {9'd0, w_pre};
    end

    // One restoring-division step: subtract the divisor if it fits, then shift
    always_comb begin
        w_ge      = (r_rem >= {2'b00, r_mant_b});
        // The remainder stays below 2*divisor, so the difference fits in 25 bits.
        w_rem_sub = r_rem[24:0] - {1'b0, r_mant_b};
        if (w_ge) begin
            w_rem_next = {w_rem_sub, 1'b0};
        end else begin
            w_rem_next = {r_rem[24:0], 1'b0};
        end
    end

    // Round to nearest even, then handle overflow to inf and flush-to-zero
    always_comb begin
        w_sticky   = (r_rem != 26'd0);
        w_round_up = r_quot[1] & (r_quot[0] | w_sticky | r_quot[2]);
        w_frac_sum = {1'b0, r_quot[24:2]} + {23'd0, w_round_up};
        // A carry out of the fraction turns 1.111..1 into 10.000..0.
        w_carry    = w_frac_sum[23];
        w_exp_rnd  = r_exp + $signed({9'd0, w_carry});
        if (w_carry) begin
            w_frac_rnd = 23'd0;
        end else begin
            w_frac_rnd = w_frac_sum[22:0];
        end
        if (w_exp_rnd >= 10'sd255) begin
            w_round_res = {r_sign, 8'hFF, 23'd0};
        end else if (w_exp_rnd <= 10'sd0) begin
            w_round_res = {r_sign, 31'd0};
        end else begin
            w_round_res = {r_sign, w_exp_rnd[7:0], w_frac_rnd};
        end
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= 32'd0;
            r_count     <= 5'd0;
            r_sign      <= 1'b0;
            r_exp       <= 10'sd0;
            r_rem       <= 26'd0;
            r_mant_b    <= 24'd0;
            r_quot      <= 25'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_sign     <= w_sign;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= DONE;
                        end else begin
                            r_rem    <= w_rem_init;
                            r_mant_b <= w_mant_b;
                            r_exp    <= $signed(w_exp_init);
                            r_quot   <= 25'd0;
                            r_count  <= 5'd0;
                            r_state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem  <= w_rem_next;
                    r_quot <= {r_quot[23:0], w_ge};
                    if (r_count == 5'd25) begin
                        r_count <= 5'd0;
                        r_state <= ROUND;
                    end else begin
                        r_count <= r_count + 5'd1;
                    end
                end
                ROUND: begin
                    r_result <= w_round_res;
                    r_state  <= DONE;
                end
                DONE: begin
                    // out_valid rises one cycle after DONE entry and stays
                    // high until the consumer takes the result.
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_count     <= 5'd0;
                end
            endcase
        end
    end

endmodule
